// File: rtl/control_riesgos_pipeline.sv
// Central stall/flush controller for the 5-stage pipeline: load-use bubbles,
// taken-branch flushes, multi-cycle data-memory waits with a timeout.
module control_riesgos_pipeline #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned TO_W        = 8,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             memwb_flush,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_ERROR    = 2'd2;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic [TO_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic             timeout_err_q, timeout_err_d;

    logic load_use;
    logic mem_stall;

    assign load_use = ex_memread && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    assign mem_stall = mem_req && !mem_ready;

    always_comb begin
        pc_en         = 1'b1;
        ifid_en       = 1'b1;
        ifid_flush    = 1'b0;
        idex_en       = 1'b1;
        idex_flush    = 1'b0;
        exmem_en      = 1'b1;
        memwb_en      = 1'b1;
        memwb_flush   = 1'b0;
        state_d       = state_q;
        wait_d        = wait_q;
        timeout_err_d = timeout_err_q;

        if (!rst_n) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            memwb_flush = 1'b1;
        end else begin
            case (state_q)
                ST_RUN, ST_MEM_WAIT: begin
                    // In MEM_WAIT a completing access behaves like RUN without a mem stall
                    if ((state_q == ST_RUN && mem_stall) ||
                        (state_q == ST_MEM_WAIT && !mem_ready)) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_en     = 1'b0;
                        exmem_en    = 1'b0;
                        memwb_flush = 1'b1;
                        if (state_q == ST_RUN) begin
                            state_d = ST_MEM_WAIT;
                            wait_d  = TO_W'(1);
                        end else if (wait_q == TO_LAST) begin
                            state_d       = ST_ERROR;
                            timeout_err_d = 1'b1;
                        end else begin
                            wait_d = wait_q + 1'b1;
                        end
                    end else begin
                        state_d = ST_RUN;
                        wait_d  = '0;
                        if (ex_branch_taken) begin
                            ifid_flush = 1'b1;
                            idex_flush = 1'b1;
                        end else if (load_use) begin
                            pc_en      = 1'b0;
                            ifid_en    = 1'b0;
                            idex_flush = 1'b1;
                        end
                    end
                end
                ST_ERROR: begin
                    pc_en         = 1'b0;
                    ifid_en       = 1'b0;
                    idex_en       = 1'b0;
                    exmem_en      = 1'b0;
                    memwb_en      = 1'b0;
                    timeout_err_d = 1'b1;
                end
                default: begin
                    state_d = ST_RUN;
                    wait_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (!pc_en && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            wait_q        <= '0;
            stall_count_q <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            stall_count_q <= stall_count_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_control_riesgos_pipeline.sv
// Scoreboard bench for control_riesgos_pipeline: driver queues hand-written
// expected control vectors, a negedge monitor pops and compares them.
module tb_control_riesgos_pipeline;

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, memwb_flush, timeout_err}
    localparam logic [8:0] NORM = 9'b1_1_0_1_0_1_1_0_0;
    localparam logic [8:0] LU   = 9'b0_0_0_1_1_1_1_0_0;
    localparam logic [8:0] BR   = 9'b1_1_1_1_1_1_1_0_0;
    localparam logic [8:0] FRZ  = 9'b0_0_0_0_0_0_1_1_0;
    localparam logic [8:0] ERR  = 9'b0_0_0_0_0_0_0_0_1;
    localparam logic [8:0] RST0 = 9'b0_0_1_0_1_0_0_1_0;
    localparam logic [8:0] RST1 = 9'b0_0_1_0_1_0_0_1_1;

    typedef struct packed {
        logic [8:0]  ctl;
        logic [15:0] cnt;
        logic [3:0]  cnt2;
        bit          chk;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic id_uses_rt, ex_memread, ex_branch_taken, mem_req, mem_ready;
    logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, memwb_flush, timeout_err;
    logic [15:0] stall_count;

    logic d2_lu;
    logic d2_pc_en, d2_ifid_en, d2_ifid_flush, d2_idex_en, d2_idex_flush;
    logic d2_exmem_en, d2_memwb_en, d2_memwb_flush, d2_timeout_err;
    logic [3:0] d2_stall_count;

    exp_t q[$];
    int n_chk = 0;
    int n_pass = 0;
    logic [15:0] exp_cnt = '0;
    logic [3:0]  exp_cnt2 = '0;

    always #5 clk = ~clk;

    control_riesgos_pipeline #(.MEM_TIMEOUT(16), .TO_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .memwb_flush(memwb_flush),
        .timeout_err(timeout_err), .stall_count(stall_count)
    );

    // Narrow-counter instance, driven only with a held load-use hazard
    control_riesgos_pipeline #(.MEM_TIMEOUT(16), .TO_W(8), .CNT_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .id_rs(5'd9), .id_rt(5'd0), .id_uses_rt(1'b0),
        .ex_memread(d2_lu), .ex_rt(5'd9), .ex_branch_taken(1'b0),
        .mem_req(1'b0), .mem_ready(1'b1),
        .pc_en(d2_pc_en), .ifid_en(d2_ifid_en), .ifid_flush(d2_ifid_flush),
        .idex_en(d2_idex_en), .idex_flush(d2_idex_flush), .exmem_en(d2_exmem_en),
        .memwb_en(d2_memwb_en), .memwb_flush(d2_memwb_flush),
        .timeout_err(d2_timeout_err), .stall_count(d2_stall_count)
    );

    task automatic idle();
        id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b1;
        ex_memread = 1'b0; ex_rt = 5'd3; ex_branch_taken = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b1;
    endtask

    task automatic cyc(input logic [8:0] e, input bit chk = 1'b1);
        exp_t x;
        x.ctl = e; x.cnt = exp_cnt; x.cnt2 = exp_cnt2; x.chk = chk;
        q.push_back(x);
        @(posedge clk);
        if (!rst_n) begin
            exp_cnt = '0;
            exp_cnt2 = '0;
        end else begin
            if (!e[8] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            if (d2_lu && exp_cnt2 != 4'hF) exp_cnt2 = exp_cnt2 + 4'd1;
        end
        #1;
    endtask

    initial begin : monitor
        exp_t x;
        logic [8:0] act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x = q.pop_front();
                if (x.chk) begin
                    act = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                           exmem_en, memwb_en, memwb_flush, timeout_err};
                    n_chk++;
                    if (act === x.ctl) n_pass++;
                    else $display("FAIL ctl t=%0t actual=%b required=%b", $time, act, x.ctl);
                    n_chk++;
                    if (stall_count === x.cnt) n_pass++;
                    else $display("FAIL stall_count t=%0t actual=%0d required=%0d", $time, stall_count, x.cnt);
                    n_chk++;
                    if (d2_stall_count === x.cnt2) n_pass++;
                    else $display("FAIL stall_count_w4 t=%0t actual=%0d required=%0d", $time, d2_stall_count, x.cnt2);
                end
            end
        end
    end

    initial begin : driver
        idle();
        d2_lu = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        cyc(RST0, 1'b0);
        cyc(RST0);
        rst_n = 1'b1;

        // Independent stream, including zero-wait accesses
        for (int i = 0; i < 20; i++) begin
            mem_req = (i % 3 == 0);
            cyc(NORM);
        end
        idle();

        // Load-use on rs, then ex_rt==0, then rt match with/without id_uses_rt
        ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        cyc(LU);
        idle(); cyc(NORM);
        ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        cyc(NORM);
        ex_rt = 5'd7; id_rs = 5'd3; id_rt = 5'd7; id_uses_rt = 1'b1;
        cyc(LU);
        id_uses_rt = 1'b0;
        cyc(NORM);

        // Taken branch suppresses load-use
        ex_rt = 5'd5; id_rs = 5'd5; ex_branch_taken = 1'b1;
        cyc(BR);
        idle(); cyc(NORM);

        // Three wait cycles then ready
        mem_req = 1'b1; mem_ready = 1'b0;
        repeat (3) cyc(FRZ);
        mem_ready = 1'b1;
        cyc(NORM);
        idle(); cyc(NORM);

        // Completion in MEM_WAIT evaluates the branch term
        mem_req = 1'b1; mem_ready = 1'b0;
        cyc(FRZ);
        mem_ready = 1'b1; ex_branch_taken = 1'b1;
        cyc(BR);
        idle();

        // mem_req is ignored while waiting
        mem_req = 1'b1; mem_ready = 1'b0;
        cyc(FRZ);
        mem_req = 1'b0;
        cyc(FRZ);
        mem_ready = 1'b1;
        cyc(NORM);

        // Timeout after 16 frozen cycles; the narrow counter saturates meanwhile
        d2_lu = 1'b1;
        mem_req = 1'b1; mem_ready = 1'b0;
        repeat (16) cyc(FRZ);
        repeat (2) cyc(ERR);
        mem_ready = 1'b1; mem_req = 1'b0;
        repeat (2) cyc(ERR);
        d2_lu = 1'b0;
        cyc(ERR);
        rst_n = 1'b0;
        cyc(RST1);
        rst_n = 1'b1;
        idle();
        repeat (2) cyc(NORM);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        n_chk++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain actual=%0d required=0 pending entries", q.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
